// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder                                                        |
// | Description : Unsigned WIDTH-bit adder with carry-in/carry-out. Carries   |
// |               are looked ahead inside GROUP-bit groups and rippled between |
// |               groups. Combinational sum/cout/ovf plus a registered copy.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module adder #(
  parameter int WIDTH = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  // Number of lookahead groups; the last one may hold fewer than GROUP bits.
  localparam int c_ngrp = (WIDTH + GROUP - 1) / GROUP;

  logic [WIDTH-1:0]  w_g;   // per-bit generate
  logic [WIDTH-1:0]  w_p;   // per-bit propagate
  logic [WIDTH-1:0]  w_c;   // carry into each bit position
  logic [c_ngrp-1:0] w_gg;  // group generate
  logic [c_ngrp-1:0] w_gp;  // group propagate
  logic [c_ngrp:0]   w_cg;  // carry into each group; last entry is cout

  assign w_g = in1 & in2;
  assign w_p = in1 ^ in2;

  for (genvar gi = 0; gi < c_ngrp; gi++) begin : g_grp
    localparam int c_lo = gi * GROUP;
    localparam int c_n  = ((c_lo + GROUP) > WIDTH) ? (WIDTH - c_lo) : GROUP;

    // Entry k holds the generate/propagate prefix of the group's lowest k bits;
    // entry c_n therefore is the whole-group generate/propagate.
    for (genvar k = 0; k <= c_n; k++) begin : g_pref
      logic w_gen;
      logic w_prop;

      // Prefix generate/propagate over bits c_lo .. c_lo+k-1, independent of any carry
      always_comb begin
        w_gen  = 1'b0;
        w_prop = 1'b1;
        for (int j = 0; j < k; j++) begin
          w_gen  = w_g[c_lo+j] | (w_p[c_lo+j] & w_gen);
          w_prop = w_prop & w_p[c_lo+j];
        end
      end

      if (k < c_n) begin : g_bitc
        // Each bit's carry is taken straight from the group carry-in.
        assign w_c[c_lo+k] = w_gen | (w_prop & w_cg[gi]);
      end else begin : g_grpgp
        assign w_gg[gi] = w_gen;
        assign w_gp[gi] = w_prop;
      end
    end
  end

  // Group carries ripple from cin through each group's generate/propagate
  always_comb begin
    w_cg[0] = cin;
    for (int gi = 0; gi < c_ngrp; gi++) begin
      w_cg[gi+1] = w_gg[gi] | (w_gp[gi] & w_cg[gi]);
    end
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_cg[c_ngrp];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf  = w_c[WIDTH-1] ^ w_cg[c_ngrp];

  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_ovf_q;

  // One-cycle registered copy of the combinational result, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q  <= '0;
      r_cout_q <= 1'b0;
      r_ovf_q  <= 1'b0;
    end else begin
      r_sum_q  <= sum;
      r_cout_q <= cout;
      r_ovf_q  <= ovf;
    end
  end

  assign sum_q  = r_sum_q;
  assign cout_q = r_cout_q;
  assign ovf_q  = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adder                                                     |
// | Description : Self-checking bench for adder at WIDTH=4 and WIDTH=7/GROUP=4 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_adder;

  logic       clk;
  logic       rst;

  logic [3:0] a4, b4, s4, sq4;
  logic       c4, co4, ov4, cq4, oq4;
  logic [6:0] a7, b7, s7, sq7;
  logic       c7, co7, ov7, cq7, oq7;

  int total;
  int bad;

  adder #(.WIDTH(4), .GROUP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in1(a4), .in2(b4), .cin(c4),
    .sum(s4), .cout(co4), .ovf(ov4), .sum_q(sq4), .cout_q(cq4), .ovf_q(oq4)
  );

  adder #(.WIDTH(7), .GROUP(4)) u_dut7 (
    .clk(clk), .rst(rst), .in1(a7), .in2(b7), .cin(c7),
    .sum(s7), .cout(co7), .ovf(ov7), .sum_q(sq7), .cout_q(cq7), .ovf_q(oq7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result in the low w+1 bits
  function automatic int ref_full(int w, int a, int b, int c);
    return (a + b + c) % (1 << (w + 1));
  endfunction

  // Reference signed overflow: operands share a sign, result sign differs
  function automatic int ref_ovf(int w, int a, int b, int c);
    int sa, sb, sr;
    sa = (a >> (w - 1)) & 1;
    sb = (b >> (w - 1)) & 1;
    sr = (ref_full(w, a, b, c) >> (w - 1)) & 1;
    return ((sa == sb) && (sr != sa)) ? 1 : 0;
  endfunction

  task automatic check4(input string tag, input int a, input int b, input int c);
    int f;
    f = ref_full(4, a, b, c);
    chk({tag, ".sum"},  32'(s4),  32'(f & 15));
    chk({tag, ".cout"}, 32'(co4), 32'(f >> 4));
    chk({tag, ".ovf"},  32'(ov4), 32'(ref_ovf(4, a, b, c)));
  endtask

  task automatic check7(input string tag, input int a, input int b, input int c);
    int f;
    f = ref_full(7, a, b, c);
    chk({tag, ".sum"},  32'(s7),  32'(f & 127));
    chk({tag, ".cout"}, 32'(co7), 32'(f >> 7));
    chk({tag, ".ovf"},  32'(ov7), 32'(ref_ovf(7, a, b, c)));
  endtask

  // in1, in2, cin, expected sum, expected cout
  int dv[13][5] = '{
    '{0, 0, 0, 0, 0},   '{0, 0, 1, 1, 0},   '{0, 15, 1, 0, 1},  '{15, 0, 1, 0, 1},
    '{7, 8, 0, 15, 0},  '{7, 8, 1, 0, 1},   '{15, 15, 0, 14, 1},'{15, 15, 1, 15, 1},
    '{15, 1, 1, 1, 1},  '{2, 5, 0, 7, 0},   '{2, 5, 1, 8, 0},   '{6, 13, 0, 3, 1},
    '{6, 13, 1, 4, 1}
  };

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a4 = '0; b4 = '0; c4 = 1'b0;
    a7 = '0; b7 = '0; c7 = 1'b0;

    // Reset state of the registered outputs
    #2;
    chk("rst.sum_q4",  32'(sq4), 32'd0);
    chk("rst.cout_q4", 32'(cq4), 32'd0);
    chk("rst.ovf_q4",  32'(oq4), 32'd0);
    chk("rst.sum_q7",  32'(sq7), 32'd0);

    // Directed table from the arithmetic rules
    for (int i = 0; i < 13; i++) begin
      a4 = 4'(dv[i][0]); b4 = 4'(dv[i][1]); c4 = 1'(dv[i][2]);
      #2;
      chk($sformatf("dir%0d.sum", i),  32'(s4),  32'(dv[i][3]));
      chk($sformatf("dir%0d.cout", i), 32'(co4), 32'(dv[i][4]));
    end

    // Signed overflow corners
    a4 = 4'd7;  b4 = 4'd1; c4 = 1'b0; #2;
    chk("ovf.7p1", 32'(ov4), 32'd1);
    a4 = 4'd15; b4 = 4'd1; c4 = 1'b0; #2;
    chk("ovf.15p1", 32'(ov4), 32'd0);

    // Registered path and asynchronous reset
    @(negedge clk);
    rst = 1'b0;
    a4 = 4'd6; b4 = 4'd13; c4 = 1'b1;
    @(posedge clk); #1;
    chk("reg.sum_q",  32'(sq4), 32'd4);
    chk("reg.cout_q", 32'(cq4), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst.sum_q",  32'(sq4), 32'd0);
    chk("arst.cout_q", 32'(cq4), 32'd0);
    chk("arst.sum",    32'(s4),  32'd4);
    chk("arst.cout",   32'(co4), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.sum_q_hold", 32'(sq4), 32'd0);
    @(posedge clk); #1;
    chk("rel.sum_q",  32'(sq4), 32'd4);
    chk("rel.cout_q", 32'(cq4), 32'd1);

    // Random registered transfers on both widths
    for (int i = 0; i < 40; i++) begin
      int ra, rb, rc, qa, qb, qc;
      @(negedge clk);
      ra = int'($urandom_range(15)); rb = int'($urandom_range(15)); rc = int'($urandom_range(1));
      qa = int'($urandom_range(127)); qb = int'($urandom_range(127)); qc = int'($urandom_range(1));
      a4 = 4'(ra); b4 = 4'(rb); c4 = 1'(rc);
      a7 = 7'(qa); b7 = 7'(qb); c7 = 1'(qc);
      @(posedge clk); #1;
      chk($sformatf("rq4_%0d.sum_q", i),  32'(sq4), 32'(ref_full(4, ra, rb, rc) & 15));
      chk($sformatf("rq4_%0d.cout_q", i), 32'(cq4), 32'(ref_full(4, ra, rb, rc) >> 4));
      chk($sformatf("rq4_%0d.ovf_q", i),  32'(oq4), 32'(ref_ovf(4, ra, rb, rc)));
      chk($sformatf("rq7_%0d.sum_q", i),  32'(sq7), 32'(ref_full(7, qa, qb, qc) & 127));
      chk($sformatf("rq7_%0d.cout_q", i), 32'(cq7), 32'(ref_full(7, qa, qb, qc) >> 7));
      chk($sformatf("rq7_%0d.ovf_q", i),  32'(oq7), 32'(ref_ovf(7, qa, qb, qc)));
    end

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); c4 = 1'(c);
          #2;
          check4($sformatf("ex4_%0d_%0d_%0d", a, b, c), a, b, c);
        end
      end
    end

    // WIDTH=7 with a partial second group: corners then random vectors
    for (int i = 0; i < 400; i++) begin
      int qa, qb, qc;
      case (i)
        0: begin qa = 127; qb = 127; qc = 1; end
        1: begin qa = 0;   qb = 127; qc = 1; end
        2: begin qa = 63;  qb = 1;   qc = 0; end
        3: begin qa = 15;  qb = 0;   qc = 1; end
        4: begin qa = 64;  qb = 64;  qc = 0; end
        default: begin
          qa = int'($urandom_range(127));
          qb = int'($urandom_range(127));
          qc = int'($urandom_range(1));
        end
      endcase
      a7 = 7'(qa); b7 = 7'(qb); c7 = 1'(qc);
      #2;
      check7($sformatf("rn7_%0d", i), qa, qb, qc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
